// File: rtl/sme_pkg.sv
// rtl/sme_pkg.sv - shared types and sizing helpers for the boolean-masked adder/subtractor
package sme_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GEN    = 2'd1,
        PREFIX = 2'd2,
        DONE   = 2'd3
    } sme_addsub_state_t;

    function automatic int sme_w(input int xlen);
        return xlen + 1;
    endfunction

    function automatic int sme_l(input int w);
        return $clog2(w);
    endfunction

    function automatic int sme_nr(input int smax);
        return smax * (smax - 1) / 2;
    endfunction

    localparam int SME_XLEN = 32;
    localparam int SME_SMAX = 4;

    typedef logic [SME_SMAX-1:0][SME_XLEN-1:0] sme_shares_t;

endpackage

// File: rtl/sme_dom_and.sv
// rtl/sme_dom_and.sv - domain-oriented masked AND of two D-share N-bit operands
module sme_dom_and
    import sme_pkg::*;
#(
    parameter int N = 33,
    parameter int D = 4,
    localparam int NR = sme_nr(D)
) (
    input  logic [D-1:0]        live,
    input  logic [D-1:0][N-1:0] a,
    input  logic [D-1:0][N-1:0] b,
    input  logic [NR*N-1:0]     rng,
    output logic [D-1:0][N-1:0] q
);

    function automatic int pair_idx(input int i, input int j);
        return i * (2 * D - i - 1) / 2 + (j - i - 1);
    endfunction

    logic [N-1:0] z;

    // Each cross-domain pair shares one random word so it cancels in the XOR of all outputs.
    // Pairs touching a dead share get no mask, which keeps dead output shares at zero.
    always_comb begin
        q = '0;
        z = '0;
        for (int i = 0; i < D; i++) begin
            q[i] = a[i] & b[i];
        end
        for (int i = 0; i < D; i++) begin
            for (int j = i + 1; j < D; j++) begin
                z    = (live[i] && live[j]) ? rng[pair_idx(i, j)*N +: N] : '0;
                q[i] = q[i] ^ (a[i] & b[j]) ^ z;
                q[j] = q[j] ^ (a[j] & b[i]) ^ z;
            end
        end
    end

endmodule

// File: rtl/sme_masked_addsub.sv
// rtl/sme_masked_addsub.sv - boolean-masked Kogge-Stone adder/subtractor over SMAX shares
module sme_masked_addsub
    import sme_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SMAX = 4,
    localparam int W  = sme_w(XLEN),
    localparam int L  = sme_l(W),
    localparam int NR = sme_nr(SMAX)
) (
    input  logic                       g_clk,
    input  logic                       g_resetn,
    output logic                       g_clk_req,
    input  logic                       flush,
    input  logic [3:0]                 smectl_d,
    input  logic                       valid,
    output logic                       ready,
    input  logic                       op_sub,
    input  logic [SMAX-1:0][XLEN-1:0]  rs1,
    input  logic [SMAX-1:0][XLEN-1:0]  rs2,
    input  logic [2*NR*W-1:0]          rng,
    output logic [SMAX-1:0][XLEN-1:0]  rd
);

    localparam int LW = $clog2(L + 1);

    sme_addsub_state_t state_q, state_d;
    logic [LW-1:0]               lvl_q, lvl_d;
    logic [SMAX-1:0]             live_q, live_d;
    logic [SMAX-1:0][W-1:0]      a_q, a_d, b_q, b_d;
    logic [SMAX-1:0][W-1:0]      p0_q, p0_d, p_q, p_d, g_q, g_d;
    logic [SMAX-1:0][XLEN-1:0]   rd_q, rd_d;

    logic [SMAX-1:0]             live_in;
    logic [SMAX-1:0][W-1:0]      ext_a, ext_b;
    logic [SMAX-1:0][W-1:0]      g_sh, p_sh;
    logic [SMAX-1:0][W-1:0]      gand_a, gand_b, gand_q, pand_q;
    logic [SMAX-1:0]             unused_p0_lsb;
    logic                        abort;
    int                          d_eff;

    // The carry-in rides in the extra LSB of share 0 only, so bit-0 generate equals op_sub.
    always_comb begin
        d_eff   = int'(smectl_d);
        if (d_eff < 2) begin
            d_eff = 2;
        end else if (d_eff > SMAX) begin
            d_eff = SMAX;
        end
        live_in = '0;
        ext_a   = '0;
        ext_b   = '0;
        for (int i = 0; i < SMAX; i++) begin
            if (i < d_eff) begin
                live_in[i] = 1'b1;
                ext_a[i]   = {rs1[i], (i == 0) ? op_sub : 1'b0};
                ext_b[i]   = {((i == 0) && op_sub) ? ~rs2[i] : rs2[i], (i == 0) ? op_sub : 1'b0};
            end
        end
    end

    always_comb begin
        g_sh          = '0;
        p_sh          = '0;
        unused_p0_lsb = '0;
        for (int i = 0; i < SMAX; i++) begin
            g_sh[i]          = g_q[i] << (1 << lvl_q);
            p_sh[i]          = p_q[i] << (1 << lvl_q);
            unused_p0_lsb[i] = p0_q[i][0];
        end
    end

    sme_dom_and #(.N(W), .D(SMAX)) u_and_g (
        .live (live_q),
        .a    (gand_a),
        .b    (gand_b),
        .rng  (rng[NR*W-1:0]),
        .q    (gand_q)
    );

    sme_dom_and #(.N(W), .D(SMAX)) u_and_p (
        .live (live_q),
        .a    (p_q),
        .b    (p_sh),
        .rng  (rng[2*NR*W-1:NR*W]),
        .q    (pand_q)
    );

    assign abort = flush || (!valid && (state_q == GEN || state_q == PREFIX));

    always_comb begin
        state_d = state_q;
        lvl_d   = lvl_q;
        live_d  = live_q;
        a_d     = a_q;
        b_d     = b_q;
        p0_d    = p0_q;
        p_d     = p_q;
        g_d     = g_q;
        rd_d    = rd_q;
        gand_a  = p_q;
        gand_b  = g_sh;
        case (state_q)
            IDLE: begin
                if (valid && !flush) begin
                    state_d = GEN;
                    live_d  = live_in;
                    a_d     = ext_a;
                    b_d     = ext_b;
                    p0_d    = ext_a ^ ext_b;
                    p_d     = ext_a ^ ext_b;
                end
            end
            GEN: begin
                gand_a  = a_q;
                gand_b  = b_q;
                g_d     = gand_q;
                lvl_d   = '0;
                state_d = PREFIX;
            end
            PREFIX: begin
                g_d   = g_q ^ gand_q;
                p_d   = pand_q;
                lvl_d = lvl_q + 1'b1;
                if (lvl_q == LW'(L - 1)) begin
                    state_d = DONE;
                    for (int i = 0; i < SMAX; i++) begin
                        rd_d[i] = p0_q[i][W-1:1] ^ g_d[i][W-2:0];
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            rd_d    = rd_q;
        end
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state_q <= IDLE;
            lvl_q   <= '0;
            live_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            p0_q    <= '0;
            p_q     <= '0;
            g_q     <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            lvl_q   <= lvl_d;
            live_q  <= live_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p0_q    <= p0_d;
            p_q     <= p_d;
            g_q     <= g_d;
            rd_q    <= rd_d;
        end
    end

    assign ready     = (state_q == DONE);
    assign g_clk_req = (state_q != IDLE) || valid;
    assign rd        = rd_q;

endmodule

// File: tb/tb_sme_masked_addsub.sv
// tb/tb_sme_masked_addsub.sv - directed and random checks for sme_masked_addsub
module tb_sme_masked_addsub;
    import sme_pkg::*;

    localparam int XLEN = 32;
    localparam int SMAX = 4;
    localparam int W    = XLEN + 1;
    localparam int NR   = SMAX * (SMAX - 1) / 2;
    localparam int NRND = 300;

    logic                 clk = 1'b0;
    logic                 resetn;
    logic                 flush;
    logic                 valid;
    logic                 op_sub;
    logic [3:0]           smectl_d;
    sme_shares_t          rs1, rs2, rd;
    logic [2*NR*W-1:0]    rng;
    logic                 ready, clk_req;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses   = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [3:0]  d;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];

    sme_masked_addsub #(.XLEN(XLEN), .SMAX(SMAX)) dut (
        .g_clk     (clk),
        .g_resetn  (resetn),
        .g_clk_req (clk_req),
        .flush     (flush),
        .smectl_d  (smectl_d),
        .valid     (valid),
        .ready     (ready),
        .op_sub    (op_sub),
        .rs1       (rs1),
        .rs2       (rs2),
        .rng       (rng),
        .rd        (rd)
    );

    always #5 clk = ~clk;

    initial begin
        logic [415:0] tmp;
        rng = '0;
        forever begin
            @(posedge clk);
            #2;
            for (int k = 0; k < 13; k++) tmp[k*32 +: 32] = $urandom;
            rng = tmp[2*NR*W-1:0];
        end
    end

    always @(negedge clk) if (ready) pulses++;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected end of test");
        $fatal(1);
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int clamp_d(input logic [3:0] dv);
        if (dv < 2) return 2;
        if (dv > SMAX) return SMAX;
        return int'(dv);
    endfunction

    function automatic logic [31:0] xor_rd();
        logic [31:0] r = '0;
        for (int i = 0; i < SMAX; i++) r ^= rd[i];
        return r;
    endfunction

    function automatic logic [31:0] dead_or(input int de);
        logic [31:0] r = '0;
        for (int i = de; i < SMAX; i++) r |= rd[i];
        return r;
    endfunction

    task automatic drive_op(input logic [31:0] a, input logic [31:0] b, input logic sub, input logic [3:0] dv);
        int de = clamp_d(dv);
        logic [31:0] xa = a, xb = b;
        rs1 = '0;
        rs2 = '0;
        for (int i = 1; i < de; i++) begin
            rs1[i] = $urandom;
            rs2[i] = $urandom;
            xa ^= rs1[i];
            xb ^= rs2[i];
        end
        rs1[0]   = xa;
        rs2[0]   = xb;
        op_sub   = sub;
        smectl_d = dv;
        valid    = 1'b1;
    endtask

    task automatic wait_ready(output int lat, input bit scramble);
        lat = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            lat++;
            if (scramble && lat == 1) begin
                rs1      = {$urandom, $urandom, $urandom, $urandom};
                rs2      = {$urandom, $urandom, $urandom, $urandom};
                op_sub   = ~op_sub;
                smectl_d = 4'($urandom);
            end
        end while (!ready && lat < 30);
        if (!ready) lat = -1;
    endtask

    task automatic do_op(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic [3:0] dv, input logic [31:0] exp);
        int lat;
        @(negedge clk);
        drive_op(a, b, sub, dv);
        wait_ready(lat, 1'b1);
        valid = 1'b0;
        check({name, "_lat"}, 128'(lat), 128'd8);
        check({name, "_sum"}, 128'(xor_rd()), 128'(exp));
        check({name, "_dead"}, 128'(dead_or(clamp_d(dv))), 128'd0);
    endtask

    initial begin
        int lat, lat2, p0, hits;
        logic [31:0] a, b, exp;
        logic sub;
        logic [3:0] dv;

        vecs[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 4'd3,  32'h00000000};
        vecs[1] = '{32'h00000005, 32'h00000007, 1'b1, 4'd4,  32'hFFFFFFFE};
        vecs[2] = '{32'h80000000, 32'h00000001, 1'b1, 4'd2,  32'h7FFFFFFF};
        vecs[3] = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 4'd4,  32'hACF13568};
        vecs[4] = '{32'h00000000, 32'h00000001, 1'b1, 4'd0,  32'hFFFFFFFF};
        vecs[5] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 4'd1,  32'h80000000};
        vecs[6] = '{32'h00000001, 32'h00000001, 1'b1, 4'd15, 32'h00000000};
        vecs[7] = '{32'h00000000, 32'h00000000, 1'b0, 4'd2,  32'h00000000};
        vecs[8] = '{32'h00000000, 32'h80000000, 1'b1, 4'd3,  32'h80000000};
        vecs[9] = '{32'hAAAAAAAA, 32'h55555555, 1'b0, 4'd4,  32'hFFFFFFFF};

        resetn   = 1'b0;
        flush    = 1'b0;
        valid    = 1'b0;
        op_sub   = 1'b0;
        smectl_d = 4'd4;
        rs1      = '0;
        rs2      = '0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        #1;
        check("reset_rd", 128'(rd), 128'd0);
        check("reset_ready", 128'(ready), 128'd0);
        check("reset_clk_req", 128'(clk_req), 128'd0);

        for (int v = 0; v < 10; v++) begin
            do_op($sformatf("vec%0d", v), vecs[v].a, vecs[v].b, vecs[v].sub, vecs[v].d, vecs[v].exp);
        end

        // Flush during cycle 4, then a fresh request in cycle 6.
        @(negedge clk);
        p0 = pulses;
        drive_op(32'h1, 32'h2, 1'b0, 4'd4);
        repeat (4) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        check("flush_ready_c4", 128'(ready), 128'd0);
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        valid = 1'b0;
        #1;
        check("flush_idle_c5", 128'(clk_req), 128'd0);
        check("flush_ready_c5", 128'(ready), 128'd0);
        check("flush_rd_kept", 128'(xor_rd()), 128'hFFFFFFFF);
        check("flush_no_pulse", 128'(pulses - p0), 128'd0);
        @(negedge clk);
        drive_op(32'h3, 32'h4, 1'b0, 4'd3);
        wait_ready(lat, 1'b1);
        valid = 1'b0;
        check("post_flush_lat", 128'(lat), 128'd8);
        check("post_flush_sum", 128'(xor_rd()), 128'h7);

        // Reset asserted in cycle 3 of an operation.
        @(negedge clk);
        drive_op(32'h10, 32'h20, 1'b0, 4'd4);
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        valid  = 1'b0;
        #1;
        check("midrst_rd", 128'(rd), 128'd0);
        check("midrst_ready", 128'(ready), 128'd0);
        check("midrst_idle", 128'(clk_req), 128'd0);
        do_op("reissue", 32'h10, 32'h20, 1'b0, 4'd4, 32'h30);

        // Back-to-back with valid held across DONE.
        @(negedge clk);
        p0 = pulses;
        drive_op(32'h00000100, 32'h00000023, 1'b1, 4'd4);
        wait_ready(lat, 1'b0);
        check("b2b_lat1", 128'(lat), 128'd8);
        check("b2b_sum1", 128'(xor_rd()), 128'h000000DD);
        drive_op(32'hDEADBEEF, 32'h11111111, 1'b0, 4'd2);
        wait_ready(lat2, 1'b0);
        valid = 1'b0;
        check("b2b_gap", 128'(lat2), 128'd9);
        check("b2b_sum2", 128'(xor_rd()), 128'hEFBED000);
        #1;
        check("b2b_pulses", 128'(pulses - p0), 128'd2);

        // Random operations against an unmasked model.
        hits = 0;
        for (int n = 0; n < NRND; n++) begin
            a   = $urandom;
            b   = $urandom;
            sub = 1'($urandom);
            dv  = 4'($urandom_range(2, 4));
            exp = sub ? (a - b) : (a + b);
            do_op($sformatf("rnd%0d", n), a, b, sub, dv, exp);
            for (int i = 0; i < clamp_d(dv); i++) if (rd[i] == exp) hits++;
        end
        n_checks++;
        if (hits > NRND / 16) begin
            n_fail++;
            $display("FAIL share_randomness: got %0d share hits expected at most %0d", hits, NRND / 16);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
